// File: rtl/lane_scheduler.sv
// lane_scheduler: four-lane traffic phase sequencer with per-lane green times and BCD countdown.
// Define LANE_SCHED_ALLRED_EN to insert a 2 s all-red phase between yellow and the next green.
module lane_scheduler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick_1hz,
    input  logic       C_EN,
    input  logic [1:0] speed_select,
    input  logic [2:0] flowspeed,
    output logic [1:0] lane,
    output logic [1:0] phase,
    output logic [3:0] D_OUT1,
    output logic [3:0] D_OUT0,
    output logic       phase_done,
    output logic       cycle_wrap
);
    typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, ALLRED = 2'b10, IDLE = 2'b11} state_t;
`ifdef LANE_SCHED_ALLRED_EN
    localparam state_t LAST = ALLRED;
`else
    localparam state_t LAST = YELLOW;
`endif
    state_t     state_q, state_d;
    logic [6:0] rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0] lane_q, lane_d;
    logic [3:0] d1_q, d0_q;
    logic       en_q, done_q, wrap_q, step, go, to_green;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (flowspeed == 3'b000) begin
            hi_d = 7'd44;
            lo_d = 7'd44;
        end else if (flowspeed == 3'b001) begin
            hi_d = 7'd55;
            lo_d = 7'd33;
        end else if (flowspeed[1:0] == 2'b11) begin
            hi_d = 7'd66;
            lo_d = 7'd22;
        end
        // en_q suppresses the tick that arrives together with C_EN rising
        step     = tick_1hz && C_EN && en_q;
        go       = step && rem_q == 7'd1;
        to_green = state_q == IDLE || (go && state_q == LAST);
        lane_d   = state_q == IDLE ? 2'd0 : to_green ? lane_q + 2'd1 : lane_q;
        state_d  = to_green ? GREEN : go ? (state_q == GREEN ? YELLOW : ALLRED) : state_q;
        rem_d    = to_green ? (lane_d == speed_select ? hi_d : lo_d)
                 : go ? (state_q == GREEN ? 7'd5 : 7'd2)
                 : step ? rem_q - 7'd1 : rem_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            rem_q   <= '0;
            hi_q    <= 7'd44;
            lo_q    <= 7'd44;
            lane_q  <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            d1_q    <= 4'(rem_d / 7'd10);
            d0_q    <= 4'(rem_d % 7'd10);
            en_q    <= C_EN;
            done_q  <= go;
            wrap_q  <= go && to_green && lane_q == 2'd3;
            if (to_green) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

    assign lane       = lane_q;
    assign phase      = state_q;
    assign D_OUT1     = d1_q;
    assign D_OUT0     = d0_q;
    assign phase_done = done_q;
    assign cycle_wrap = wrap_q;
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: scoreboard bench for lane_scheduler; a per-second reference model queues
// the expected lane/phase/BCD/pulse values before each tick and they are compared after it.
module tb_lane_scheduler;
    logic       CLK = 0, RST = 1, tick_1hz = 0, C_EN = 1, prev_en = 0;
    logic [1:0] speed_select = 0;
    logic [2:0] flowspeed = 0;
    logic [1:0] lane, phase;
    logic [3:0] D_OUT1, D_OUT0;
    logic       phase_done, cycle_wrap;

    lane_scheduler dut (
        .CLK(CLK), .RST(RST), .tick_1hz(tick_1hz), .C_EN(C_EN),
        .speed_select(speed_select), .flowspeed(flowspeed),
        .lane(lane), .phase(phase), .D_OUT1(D_OUT1), .D_OUT0(D_OUT0),
        .phase_done(phase_done), .cycle_wrap(cycle_wrap)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) prev_en <= C_EN;

    typedef struct {int lane; int phase; int rem; int done; int wrap;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    int m_lane, m_phase, m_rem, m_hi, m_lo, obs_wraps, allred_seen;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_enter_green(input bit first);
        if (flowspeed == 3'd0) begin m_hi = 44; m_lo = 44; end
        else if (flowspeed == 3'd1) begin m_hi = 55; m_lo = 33; end
        else if (flowspeed == 3'd3 || flowspeed == 3'd7) begin m_hi = 66; m_lo = 22; end
        if (!first) m_lane = (m_lane + 1) % 4;
        m_rem   = (m_lane == int'(speed_select)) ? m_hi : m_lo;
        m_phase = 0;
    endtask

    task automatic compare(input exp_t e);
        chk("lane", lane, e.lane);
        chk("phase", phase, e.phase);
        chk("tens", D_OUT1, e.rem / 10);
        chk("units", D_OUT0, e.rem % 10);
        chk("phase_done", phase_done, e.done);
        chk("cycle_wrap", cycle_wrap, e.wrap);
    endtask

    task automatic tick();
        exp_t e;
        bit   cnt = C_EN && prev_en;
        e.done = 0;
        e.wrap = 0;
        if (cnt) begin
            if (m_rem > 1) m_rem--;
            else begin
                e.done = 1;
                if (m_phase == 0) begin m_phase = 1; m_rem = 5; end
`ifdef LANE_SCHED_ALLRED_EN
                else if (m_phase == 1) begin m_phase = 2; m_rem = 2; end
`endif
                else begin m_enter_green(0); e.wrap = (m_lane == 0); end
            end
        end
        e.lane = m_lane; e.phase = m_phase; e.rem = m_rem;
        sb.push_back(e);
        tick_1hz = 1;
        @(posedge CLK); #1;
        tick_1hz = 0;
        if (cycle_wrap) obs_wraps++;
        if (phase == 2'b10) allred_seen++;
        compare(sb.pop_front());
        @(posedge CLK); #1;
        chk("done_pulse_width", phase_done, 0);
        chk("wrap_pulse_width", cycle_wrap, 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic run_until(input int l, input int p, input int r);
        int n = 0;
        while (!(m_lane == l && m_phase == p && m_rem == r) && n < 400) begin
            tick();
            n++;
        end
        chk("run_until_bound", int'(n < 400), 1);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge CLK); #3;
        RST = 0;
        #1;
        e = '{lane: 0, phase: 3, rem: 0, done: 0, wrap: 0};
        compare(e);
        sb.delete();
        m_hi = 44; m_lo = 44; m_lane = 0; m_phase = 3; m_rem = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1;
        #1;
        chk("idle_phase", phase, 3);
        @(posedge CLK); #1;
        m_enter_green(1);
        e = '{lane: m_lane, phase: m_phase, rem: m_rem, done: 0, wrap: 0};
        compare(e);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        do_reset();
        chk("first_green_44", D_OUT1 * 10 + D_OUT0, 44);
        repeat (44) tick();
        chk("yellow_entry_phase", phase, 1);
        chk("yellow_entry_rem", D_OUT1 * 10 + D_OUT0, 5);
        run_until(1, 0, 44);
        repeat (10) tick();
        flowspeed = 3'b001;
        run_until(2, 0, 33);
        chk("lane2_green_33", D_OUT1 * 10 + D_OUT0, 33);
        flowspeed = 3'b010;
        run_until(3, 0, 33);
        chk("kept_table_33", D_OUT1 * 10 + D_OUT0, 33);
        run_until(0, 0, 55);
        chk("prio_lane0_55", D_OUT1 * 10 + D_OUT0, 55);
        speed_select = 2;
        flowspeed    = 3'b011;
        run_until(1, 0, 22);
        obs_wraps = 0;
        run_until(2, 0, 66);
        chk("prio_lane2_66", D_OUT1 * 10 + D_OUT0, 66);
        run_until(0, 0, 22);
        run_until(1, 0, 22);
        chk("wraps_per_cycle", obs_wraps, 1);
        run_until(1, 0, 17);
        C_EN = 0;
        repeat (20) tick();
        chk("frozen_17", D_OUT1 * 10 + D_OUT0, 17);
        C_EN = 1;
        tick();
        chk("rising_tick_ignored", D_OUT1 * 10 + D_OUT0, 17);
        tick();
        chk("resume_16", D_OUT1 * 10 + D_OUT0, 16);
        run_until(1, 1, 3);
        flowspeed = 3'b010;
        do_reset();
        chk("reset_table_44", D_OUT1 * 10 + D_OUT0, 44);
        chk("no_done_after_abort", phase_done, 0);
        repeat (3) tick();
`ifdef LANE_SCHED_ALLRED_EN
        chk("allred_seen", int'(allred_seen > 0), 1);
`else
        chk("allred_seen", allred_seen, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_scheduler.md
LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state on its rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port tick_1hz, input, 1, single-CLK-cycle enable pulse, one per second.
REQ-004 SHALL have port C_EN, input, 1, count enable; 0 freezes all countdown and state.
REQ-005 SHALL have port speed_select, input, 2, index of the priority lane (0..3).
REQ-006 SHALL have port flowspeed, input, 3, traffic level code.
REQ-007 SHALL have port lane, output, 2, index of the lane currently served.
REQ-008 SHALL have port phase, output, 2, 00 green, 01 yellow, 10 all-red, 11 idle.
REQ-009 SHALL have port D_OUT1 and D_OUT0, output, 4 each, BCD tens and units of remaining seconds.
REQ-010 SHALL have port phase_done, output, 1, one-cycle pulse on every phase transition.
REQ-011 SHALL have port cycle_wrap, output, 1, one-cycle pulse when lane wraps 3->0.

Function
REQ-012 SHALL implement FSM IDLE -> GREEN -> YELLOW -> [ALLRED] -> GREEN (next lane).
- IDLE lasts exactly one CLK after reset release, then enters GREEN of lane 0.
REQ-013 SHALL compute green duration at GREEN entry from the latched configuration:
- flowspeed 000: 44 s for all lanes.
- flowspeed 001: priority lane 55 s, others 33 s.
- flowspeed 011 or 111: priority lane 66 s, others 22 s.
- Any other code: keep the previously latched table.
REQ-014 SHALL latch speed_select and flowspeed only at GREEN entry; mid-phase changes take effect on the next green.
REQ-015 SHALL fix YELLOW at 5 s and ALLRED at 2 s.
REQ-016 SHALL load the remaining count on phase entry and decrement it on each tick_1hz with C_EN=1.
REQ-017 SHALL take the transition on the tick where remaining==1, so a phase of N s spans exactly N ticks.
REQ-018 SHALL present remaining as two BCD digits, registered, range 0..66, updated in the same cycle as the count.
REQ-019 SHALL increment lane modulo 4 at GREEN entry, except the first green after IDLE, which uses lane 0.
REQ-020 SHALL pulse phase_done in the cycle after each transition; cycle_wrap coincides with phase_done when lane goes 3->0.
REQ-021 SHALL ignore tick_1hz while C_EN=0; a tick coinciding with C_EN rising is ignored.
REQ-022 SHALL produce all outputs from registers with no combinational input-to-output path.

Reset
REQ-023 SHALL on RST=0 asynchronously set state IDLE, lane=0, phase=11, D_OUT1=0, D_OUT0=0, phase_done=0, cycle_wrap=0, latched table all 44.
REQ-024 SHALL abort any phase when reset is asserted mid-operation and restart from IDLE, with no pulse emitted for the aborted phase.

Configuration
REQ-025 SHALL gate the ALLRED phase with macro LANE_SCHED_ALLRED_EN.
- Defined: YELLOW -> ALLRED (2 s) -> GREEN.
- Undefined: YELLOW -> GREEN directly; phase code 10 is never output.

Verification
REQ-026 Reset release, flowspeed=000, C_EN=1, ticks every 4 CLKs -> lane 0 green shows 44 counting down to 1; 44 ticks later phase=01 with remaining 05.
REQ-027 speed_select=2, flowspeed=011 -> lanes 0,1,3 get 22 s green and lane 2 gets 66 s; cycle_wrap pulses once per full 4-lane cycle.
REQ-028 flowspeed changes 000->001 at the 10th second of lane 1 green -> lane 1 completes 44 s; lane 2 green loads 33 s (speed_select=0).
REQ-029 C_EN=0 for 20 ticks at remaining=17 -> remaining holds 17; counting resumes from 17 when C_EN returns to 1.
REQ-030 With LANE_SCHED_ALLRED_EN defined -> phase 10 lasts 2 ticks between yellow and green; undefined -> phase 10 never appears.
REQ-031 RST pulsed low during yellow at remaining=3 -> outputs match reset values immediately; after release, lane 0 green starts with no phase_done for the aborted yellow.
